read_data: RTL
==============

# read_data

Serial-in reader for a 74HC165-style parallel-in/serial-out shift register, and the input-side counterpart of the 74HC595 loader. On `start`, the block drives the chip's parallel-load and shift-clock pins. It samples the chip's serial output MSB-first and presents the captured word on `data` with a one-cycle `finish` pulse. It sits between button/switch input hardware and the game logic. All pin timing is derived from `clk` by clock enables, with no generated clocks.

## Interface
- `HALF`, default 4: system-clock cycles per CP half-period; must be ≥1.
- `WIDTH`, default 8: bits per transfer; 16 and 24 are used for daisy-chained chips.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transfer; sampled only in IDLE.
- `Q7`  in  1  serial data from the shift register. Already synchronised externally.
- `PL`  out  1  parallel load, active-low.
- `CP`  out  1  shift clock to the chip; rising edge shifts.
- `data`  out  WIDTH  last captured word, MSB = first bit sampled.
- `busy`  out  1  high while a transfer is in progress.
- `finish`  out  1  one-cycle pulse when `data` is updated.

## Operation
- States:
  - IDLE: `PL`=1, `CP`=0. Sampling `start`=1 moves to LOAD.
  - LOAD: `PL`=0 for 2·HALF cycles, then LOW.
  - LOW: `PL`=1, `CP`=0 for HALF cycles. At the last edge, shift Q7 into the shift register LSB. If WIDTH bits have been taken, go to IDLE and update `data`/`finish`; otherwise go to HIGH.
  - HIGH: `CP`=1 for HALF cycles, then LOW.
- Exactly WIDTH samples and WIDTH−1 CP rising edges per transfer.
- At the final sample edge, `data` ← {shift[WIDTH−2:0], Q7}. `finish`=1 for that one following cycle and the state returns to IDLE on the same edge.
- `start` outside IDLE is ignored. It is not queued.
- If `start`=1 during the `finish` cycle (IDLE), it is accepted. A held `start` therefore gives back-to-back transfers.
- `data` holds its value between transfers. A transfer aborted by reset never updates `data`.

## Timing
- All outputs are registered.
- Reset values: `PL`=1, `CP`=0, `data`=0, `busy`=0, `finish`=0, state IDLE, counters 0.
- Reset mid-transfer: the above values take effect on the next edge. `finish` is not pulsed.
- `start` is sampled at edge E0. Registered outputs then change as follows:
  - `PL`=0 from just after E0 through E2H.
  - The first sample is taken at E3H.
  - Subsequent samples are taken at E(3H+2H·k).
  - The final sample is taken at E(H·(2W+1)), where H = HALF and W = WIDTH. For defaults, this is E68.
  - `finish` is high from E(H·(2W+1)) to the next edge.
- `busy` is 1 from E0 to the final sample edge, and 0 in the `finish` cycle.
- Q7 setup before each sample is ≥HALF cycles after the preceding `PL` rise or CP rise.
- Phase counter width is clog2(2·HALF). Bit counter width is clog2(WIDTH+1). Neither counter wraps within a transfer.

## Structure
- Package `read_data_pkg`: state enum (IDLE, LOAD, LOW, HIGH) and a localparam for the latency formula H·(2W+1), which the bench reuses.
- One sub-module, `phase_tick`:
  - A restartable down-counter that pulses `tick` after N cycles, with N = HALF or 2·HALF selected by input.
  - It replaces a clock divider, so no derived clocks are used.
- The FSM, shift register and bit counter stay in `read_data`.

## Test plan
- HALF=4, WIDTH=8, chip model loaded with 0xA5, single `start` pulse -> `data`=0xA5 and `finish` high for exactly one cycle at E68. `PL` low for exactly 8 cycles, 7 CP rising edges, `busy` high E0–E68.
- Reset asserted for one cycle at E30 of a transfer -> next edge `PL`=1, `CP`=0, `busy`=0. No `finish`, and `data` retains its prior value (0 after power-up).
- `start` pulsed again at E20 and E50 of a transfer -> ignored. Exactly one `finish`, at E68.
- `start` held high, model values 0x3C then 0xC3 -> `finish` at E68 and E137. `data` is 0x3C, then 0xC3.
- HALF=1, WIDTH=16, chained models holding 0xBEEF -> `data`=0xBEEF and `finish` at E33. CP high and low phases are each 1 cycle.
- Patterns 0x00 and 0xFF, then 0x01 and 0x80 -> exact bit order confirmed (MSB first), with no off-by-one on the first or last bit.

Source files
------------

// File: rtl/read_data_pkg.sv
`default_nettype none
// ============================================================================
// Module      : read_data_pkg
// Description : Shared state encoding and latency helper for the 74HC165 reader.
// Revision    : 1.0  initial release
// ============================================================================
package read_data_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        LOW  = 2'd2,
        HIGH = 2'd3
    } state_e;

    localparam int DEFAULT_HALF  = 4;
    localparam int DEFAULT_WIDTH = 8;

    // Edges from the start-sampling edge to the final sample edge.
    function automatic int transfer_latency(input int half, input int width);
        return half * (2 * width + 1);
    endfunction

    localparam int DEFAULT_LATENCY = transfer_latency(DEFAULT_HALF, DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/read_data_phase_tick.sv
`default_nettype none
// ============================================================================
// Module      : phase_tick
// Description : Restartable down-counter; tick is high once HALF or 2*HALF
//               cycles have elapsed since the last restart.
// Revision    : 1.0  initial release
// ============================================================================
module phase_tick #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic long_sel,
    output logic tick
);

    localparam int CW = $clog2(2 * HALF);
    localparam logic [CW-1:0] SHORT_RELOAD = CW'(HALF - 1);
    localparam logic [CW-1:0] LONG_RELOAD  = CW'(2 * HALF - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = long_sel ? LONG_RELOAD : SHORT_RELOAD;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/read_data.sv
`default_nettype none
// ============================================================================
// Module      : read_data
// Description : Serial-in reader for a 74HC165-style PISO chain; drives PL/CP
//               and captures Q7 MSB-first into data with a finish pulse.
// Revision    : 1.0  initial release
// ============================================================================
module read_data
    import read_data_pkg::*;
#(
    parameter int HALF  = DEFAULT_HALF,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Q7,
    output logic             PL,
    output logic             CP,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             finish
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pl_q, pl_d;
    logic             cp_q, cp_d;
    logic             busy_q, busy_d;
    logic             finish_q, finish_d;

    logic             tick;
    logic             restart;
    logic             long_sel;
    logic [WIDTH-1:0] captured;

    phase_tick #(
        .HALF(HALF)
    ) u_phase_tick (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .long_sel (long_sel),
        .tick     (tick)
    );

    assign captured = {shift_q, Q7};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        finish_d  = 1'b0;
        restart   = 1'b0;
        long_sel  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    restart   = 1'b1;
                    long_sel  = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                if (tick) begin
                    state_d = LOW;
                    restart = 1'b1;
                end
            end
            LOW: begin
                // Sample on the last edge of the low phase, after Q7 has settled.
                if (tick) begin
                    shift_d   = captured[WIDTH-2:0];
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d  = IDLE;
                        data_d   = captured;
                        finish_d = 1'b1;
                    end else begin
                        state_d = HIGH;
                        restart = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (tick) begin
                    state_d = LOW;
                    restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin outputs follow the next state so they are registered with it.
        pl_d   = (state_d != LOAD);
        cp_d   = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            pl_q      <= 1'b1;
            cp_q      <= 1'b0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            pl_q      <= pl_d;
            cp_q      <= cp_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
        end
    end

    assign PL     = pl_q;
    assign CP     = cp_q;
    assign data   = data_q;
    assign busy   = busy_q;
    assign finish = finish_q;

endmodule
`default_nettype wire
